mux_select_stage: RTL and testbench
===================================

MUX_SELECT_STAGE -- requirements
Module: mux_select_stage

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 16, data width per channel.
- NCH, 4, channel count, 2..16.
- SELW, 2, select width; SHALL equal ceil(log2(NCH)).
REQ-002 Ports SHALL be:
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- MODE  in  1  0 = explicit select via S; 1 = round-robin among valid channels.
- S  in  SELW  channel select, used when MODE=0.
- IN_DATA  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- IN_VALID  in  NCH  per-channel valid.
- IN_READY  out  NCH  per-channel ready, combinational.
- FLUSH  in  1  discard the held output word.
- O  out  WIDTH  registered selected data.
- O_VALID  out  1  O holds a word.
- O_READY  in  1  downstream accepts O.
- O_CH  out  SELW  channel index that supplied O.
- SEL_ERR  out  1  registered one-cycle pulse: S out of range.

Function
REQ-003 The block SHALL hold a one-entry output register, either empty or full; O, O_CH and O_VALID SHALL come only from this register.
- Latency: input transfer at edge n gives O_VALID=1 with that data after edge n.
REQ-004 Load-permit: load_ok = !FLUSH && (!O_VALID || O_READY).
REQ-005 Grant selection:
- MODE=0: grant = S when S<NCH and IN_VALID[S]=1; otherwise no grant.
- MODE=1: grant = first k with IN_VALID[k]=1, searching ptr+1, ptr+2, ... modulo NCH.
REQ-006 IN_READY[grant] SHALL equal load_ok; every other IN_READY bit SHALL be 0.
- With no grant, all IN_READY bits SHALL be 0.
REQ-007 Input transfer = grant exists && load_ok. On transfer the register SHALL capture O = IN_DATA[grant], O_CH = grant, O_VALID = 1.
REQ-008 Output transfer = O_VALID && O_READY.
- With output transfer and no input transfer in the same cycle, O_VALID SHALL become 0.
- Simultaneous input and output transfer SHALL replace the word without a bubble.
REQ-009 When O_VALID=1 and O_READY=0, O and O_CH SHALL hold stable.
REQ-010 FLUSH=1 SHALL clear O_VALID at the next edge and block any input transfer that cycle.
- FLUSH takes priority over O_READY.
- O and O_CH values after a flush are don't-care.
REQ-011 Round-robin pointer ptr (SELW bits) SHALL update to grant only on an input transfer in MODE=1.
- MODE=0 transfers SHALL NOT change ptr.
- A MODE change SHALL take effect the same cycle; ptr is retained.
REQ-012 SEL_ERR SHALL be 1 for exactly the cycle after any cycle with MODE=0, S>=NCH and !FLUSH; no transfer SHALL occur in that cycle.
REQ-013 When NCH is a power of two, S>=NCH is impossible and SEL_ERR SHALL stay 0.
REQ-014 ptr wrap: the search SHALL wrap from NCH-1 to 0.
- A lone valid channel equal to ptr SHALL be granted.

Reset
REQ-015 RST_N=0 SHALL immediately and asynchronously force O_VALID=0, O=0, O_CH=0, SEL_ERR=0, ptr=NCH-1, so the first round-robin search starts at channel 0.
REQ-016 A word held when reset asserts SHALL be lost.
- The first transfer after deassertion SHALL behave as from the empty state.

Structure
REQ-017 A shared package SHALL hold the MODE encodings (MODE_EXPLICIT=0, MODE_RR=1) and a clog2 helper function.
REQ-018 One sub-module, rr_grant, SHALL implement the combinational round-robin search: inputs valid vector and ptr; outputs grant index and grant-found flag.
- The output register, ptr and SEL_ERR SHALL live in mux_select_stage.

Verification
REQ-019 The bench SHALL cover these directed scenarios (WIDTH=16, NCH=4 unless stated):
- MODE=0; S cycles 0..3; IN_DATA = 0x1111, 0x2222, 0x3333, 0x4444; all valid; O_READY=1 -> each value appears on O one cycle later with the matching O_CH.
- MODE=1; all four valid held; O_READY=1 -> O_CH sequence 0,1,2,3,0,1; IN_READY one-hot and rotating.
- MODE=1; only channels 1 and 3 valid -> O_CH alternates 1,3,1,3; IN_READY[0] and IN_READY[2] stay 0.
- O_VALID=1 with O=0xBEEF, O_READY=0 for 5 cycles -> O stable at 0xBEEF, all IN_READY=0; O_READY=1 with new data valid -> next word appears with no bubble.
- FLUSH=1 while O_VALID=1 and O_READY=1 -> O_VALID=0 next cycle, no IN_READY asserted that cycle. NCH=3 with S=3 -> SEL_ERR pulses one cycle, O_VALID unchanged.
- RST_N low mid-stream, asynchronously between edges -> O_VALID=0 and O=0 without a clock edge; after release, MODE=1 first grant is channel 0.

Source files
------------

// File: rtl/mux_select_stage_pkg.sv
// ---------------------------------------------------------------------------
// mux_select_stage_pkg
// Shared definitions for the mux_select_stage block and its round-robin
// search sub-module.
//   mode_e  : MODE input encoding (explicit select vs. round-robin)
//   clog2   : ceiling log2, used to size channel-index fields
// ---------------------------------------------------------------------------
package mux_select_stage_pkg;

    typedef enum logic {
        MODE_EXPLICIT = 1'b0,
        MODE_RR       = 1'b1
    } mode_e;

    // Smallest r with 2**r >= n (returns 0 for n <= 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_select_stage_rr_grant.sv
// ---------------------------------------------------------------------------
// rr_grant
// Combinational round-robin search. Starting one past ptr and wrapping
// modulo NCH, returns the first channel whose valid bit is set.
// A lone valid channel equal to ptr is found last (offset NCH).
// Ports:
//   valid [NCH-1:0]  in   per-channel request
//   ptr   [SELW-1:0] in   last granted channel (must be < NCH)
//   grant [SELW-1:0] out  winning channel index (0 when none)
//   found            out  at least one channel requested
// ---------------------------------------------------------------------------
module rr_grant
    import mux_select_stage_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = clog2(NCH)
) (
    input  logic [NCH-1:0]  valid,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            found
);

    // cand[gi] is the channel visited at search offset gi+1 from ptr.
    logic [SELW-1:0] cand       [NCH];
    logic [NCH-1:0]  cand_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_cand
            logic [SELW:0] sum;
            // ptr < NCH and offset <= NCH, so one conditional subtract wraps.
            assign sum = {1'b0, ptr} + (SELW+1)'(gi + 1);
            assign cand[gi] = (sum >= (SELW+1)'(NCH)) ? SELW'(sum - (SELW+1)'(NCH))
                                                       : SELW'(sum);
            assign cand_valid[gi] = valid[cand[gi]];
        end
    endgenerate

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cand_valid[i]) begin
                grant = cand[i];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_select_stage.sv
// ---------------------------------------------------------------------------
// mux_select_stage
// Selects one of NCH input channels (explicit select or round-robin) into a
// one-entry registered output stage with valid/ready handshaking.
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   mode                       0 = explicit select via s, 1 = round-robin
//   s        [SELW-1:0]        explicit channel select
//   in_data  [NCH*WIDTH-1:0]   channel k at [k*WIDTH +: WIDTH]
//   in_valid [NCH-1:0]         per-channel valid
//   in_ready [NCH-1:0]         per-channel ready (combinational)
//   flush                      discard held word, block loading this cycle
//   o        [WIDTH-1:0]       registered output word
//   o_valid                    output register full
//   o_ready                    downstream accepts o
//   o_ch     [SELW-1:0]        channel that supplied o
//   sel_err                    one-cycle pulse: s was out of range
// ---------------------------------------------------------------------------
module mux_select_stage
    import mux_select_stage_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      s,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 flush,
    output logic [WIDTH-1:0]     o,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [SELW-1:0]      o_ch,
    output logic                 sel_err
);

    // Channel slots are padded to 2**SELW so any select value indexes safely;
    // padded slots read as invalid / zero data.
    localparam int NSLOT = 1 << SELW;

    logic [WIDTH-1:0] ch_data [NSLOT];
    logic [NSLOT-1:0] valid_pad;
    logic             s_in_range;

    logic [SELW-1:0]  rr_idx;
    logic             rr_found;
    logic [SELW-1:0]  grant;
    logic             grant_found;
    logic             load_ok;
    logic             in_xfer;
    logic             out_xfer;

    logic [WIDTH-1:0] o_q,       o_d;
    logic [SELW-1:0]  o_ch_q,    o_ch_d;
    logic             o_valid_q, o_valid_d;
    logic [SELW-1:0]  ptr_q,     ptr_d;
    logic             sel_err_q, sel_err_d;

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NCH) begin : g_real
                assign ch_data[gi]   = in_data[gi*WIDTH +: WIDTH];
                assign valid_pad[gi] = in_valid[gi];
            end else begin : g_pad
                assign ch_data[gi]   = '0;
                assign valid_pad[gi] = 1'b0;
            end
        end

        // With a power-of-two channel count every select value is legal.
        if (NSLOT > NCH) begin : g_range_chk
            assign s_in_range = ({1'b0, s} < (SELW+1)'(NCH));
        end else begin : g_range_all
            assign s_in_range = 1'b1;
        end
    endgenerate

    rr_grant #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_grant (
        .valid (in_valid),
        .ptr   (ptr_q),
        .grant (rr_idx),
        .found (rr_found)
    );

    always_comb begin
        grant       = s;
        grant_found = s_in_range && valid_pad[s];
        if (mode_e'(mode) == MODE_RR) begin
            grant       = rr_idx;
            grant_found = rr_found;
        end
    end

    assign load_ok  = !flush && (!o_valid_q || o_ready);
    assign in_xfer  = grant_found && load_ok;
    assign out_xfer = o_valid_q && o_ready;

    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ready
            assign in_ready[gi] = in_xfer && (grant == SELW'(gi));
        end
    endgenerate

    always_comb begin
        o_d       = o_q;
        o_ch_d    = o_ch_q;
        o_valid_d = o_valid_q;
        ptr_d     = ptr_q;
        if (flush) begin
            o_valid_d = 1'b0;
        end else if (in_xfer) begin
            // Covers the simultaneous in/out case: replace with no bubble.
            o_d       = ch_data[grant];
            o_ch_d    = grant;
            o_valid_d = 1'b1;
        end else if (out_xfer) begin
            o_valid_d = 1'b0;
        end
        if (in_xfer && (mode_e'(mode) == MODE_RR)) begin
            ptr_d = grant;
        end
        sel_err_d = (mode_e'(mode) == MODE_EXPLICIT) && !s_in_range && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q       <= '0;
            o_ch_q    <= '0;
            o_valid_q <= 1'b0;
            // NCH-1 makes the first round-robin search begin at channel 0.
            ptr_q     <= SELW'(NCH - 1);
            sel_err_q <= 1'b0;
        end else begin
            o_q       <= o_d;
            o_ch_q    <= o_ch_d;
            o_valid_q <= o_valid_d;
            ptr_q     <= ptr_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign o       = o_q;
    assign o_ch    = o_ch_q;
    assign o_valid = o_valid_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_select_stage.sv
// ---------------------------------------------------------------------------
// tb_mux_select_stage
// Two instances share one stimulus stream: NCH=4 (power of two) and NCH=3
// (out-of-range select possible). A reference model predicts per-cycle ready
// vectors and select errors, and queues expected output words; a monitor
// pops and compares whenever an instance presents or hands off a word.
// ---------------------------------------------------------------------------
module tb_mux_select_stage;

    typedef struct {
        logic [15:0] data;
        int          ch;
    } word_t;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  s;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic        flush;
    logic        o_ready;

    logic [3:0]  in_ready0;
    logic [15:0] o0;
    logic        o_valid0;
    logic [1:0]  o_ch0;
    logic        sel_err0;

    logic [2:0]  in_ready1;
    logic [15:0] o1;
    logic        o_valid1;
    logic [1:0]  o_ch1;
    logic        sel_err1;

    int total = 0;
    int bad   = 0;

    bit    m_full [2];
    int    m_ptr  [2];
    bit    m_err  [2];
    word_t sb0 [$];
    word_t sb1 [$];

    mux_select_stage #(.WIDTH(16), .NCH(4), .SELW(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .s(s),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
        .flush(flush), .o(o0), .o_valid(o_valid0), .o_ready(o_ready),
        .o_ch(o_ch0), .sel_err(sel_err0)
    );

    mux_select_stage #(.WIDTH(16), .NCH(3), .SELW(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .s(s),
        .in_data(in_data[47:0]), .in_valid(in_valid[2:0]), .in_ready(in_ready1),
        .flush(flush), .o(o1), .o_valid(o_valid1), .o_ready(o_ready),
        .o_ch(o_ch1), .sel_err(sel_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            m_full[d] = 1'b0;
            m_ptr[d]  = (d == 0) ? 3 : 2;
            m_err[d]  = 1'b0;
        end
        sb0.delete();
        sb1.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_o_valid", 0, 32'(o_valid0), 0);
        chk("rst_o",       0, 32'(o0), 0);
        chk("rst_o_ch",    0, 32'(o_ch0), 0);
        chk("rst_sel_err", 0, 32'(sel_err0), 0);
        chk("rst_o_valid", 1, 32'(o_valid1), 0);
        chk("rst_o",       1, 32'(o1), 0);
        chk("rst_o_ch",    1, 32'(o_ch1), 0);
        chk("rst_sel_err", 1, 32'(sel_err1), 0);
    endtask

    // Reference model for one instance over one cycle (inputs stable).
    task automatic model_step(input int d);
        int         nch;
        int         g;
        int         c;
        bit         load_ok;
        logic [3:0] act_rdy;
        logic       act_err;
        logic [3:0] exp_rdy;
        word_t      w;
        nch = (d == 0) ? 4 : 3;
        if (d == 0) begin
            act_rdy = in_ready0;
            act_err = sel_err0;
        end else begin
            act_rdy = {1'b0, in_ready1};
            act_err = sel_err1;
        end
        chk("sel_err", d, 32'(act_err), 32'(m_err[d]));

        load_ok = !flush && (!m_full[d] || o_ready);
        g = -1;
        if (mode == 1'b0) begin
            if (int'(s) < nch && in_valid[s]) g = int'(s);
        end else begin
            for (int k = 1; k <= nch; k++) begin
                c = (m_ptr[d] + k) % nch;
                if (g < 0 && in_valid[c]) g = c;
            end
        end
        exp_rdy = (g >= 0 && load_ok) ? 4'(1 << g) : 4'h0;
        chk("in_ready", d, 32'(act_rdy), 32'(exp_rdy));

        m_err[d] = (mode == 1'b0) && (int'(s) >= nch) && !flush;
        if (flush) begin
            m_full[d] = 1'b0;
        end else if (g >= 0 && load_ok) begin
            m_full[d] = 1'b1;
            w.data = in_data[g*16 +: 16];
            w.ch   = g;
            if (d == 0) sb0.push_back(w);
            else        sb1.push_back(w);
        end else if (m_full[d] && o_ready) begin
            m_full[d] = 1'b0;
        end
        if (g >= 0 && load_ok && mode == 1'b1) m_ptr[d] = g;
    endtask

    // Monitor: compares the presented word with the scoreboard head and
    // retires it on handoff (o_ready) or discard (flush).
    task automatic mon(input int d);
        logic        ov;
        logic [15:0] od;
        logic [1:0]  oc;
        int          sz;
        word_t       f;
        if (d == 0) begin ov = o_valid0; od = o0; oc = o_ch0; sz = sb0.size(); end
        else        begin ov = o_valid1; od = o1; oc = o_ch1; sz = sb1.size(); end
        chk("o_valid", d, 32'(ov), 32'(sz > 0));
        if (ov && sz > 0) begin
            f = (d == 0) ? sb0[0] : sb1[0];
            chk("o", d, 32'(od), 32'(f.data));
            chk("o_ch", d, 32'(oc), 32'(f.ch));
            if (o_ready || flush) begin
                if (d == 0) void'(sb0.pop_front());
                else        void'(sb1.pop_front());
                if (!flush) $display("dut%0d out ch=%0d data=%h", d, oc, od);
                else        $display("dut%0d flushed ch=%0d data=%h", d, oc, od);
            end
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            mon(0);
            mon(1);
        end
    end

    task automatic drive(input logic md, input logic [1:0] sv, input logic [3:0] vv,
                         input logic [63:0] dv, input logic rdy, input logic fl);
        @(posedge clk);
        #1;
        mode     = md;
        s        = sv;
        in_valid = vv;
        in_data  = dv;
        o_ready  = rdy;
        flush    = fl;
        #2;
        model_step(0);
        model_step(1);
    endtask

    task automatic idle_inputs();
        mode     = 1'b0;
        s        = 2'd0;
        in_valid = 4'h0;
        in_data  = 64'h0;
        o_ready  = 1'b0;
        flush    = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    logic [63:0] d_seq;
    logic [63:0] d_beef;

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        reset_model();
        #3;
        check_reset_outputs();
        #14;
        rst_n = 1'b1;

        // Explicit select, fixed channel data.
        d_seq = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        for (int i = 0; i < 4; i++) drive(1'b0, 2'(i), 4'hF, d_seq, 1'b1, 1'b0);

        // Round-robin, all channels valid.
        repeat (6) drive(1'b1, 2'd0, 4'hF, rnd64(), 1'b1, 1'b0);

        // Round-robin, only channels 1 and 3.
        repeat (4) drive(1'b1, 2'd0, 4'b1010, rnd64(), 1'b1, 1'b0);

        // Stall with 0xBEEF held, then replace without a bubble.
        d_beef = {48'h0, 16'hBEEF};
        drive(1'b0, 2'd0, 4'h1, d_beef, 1'b1, 1'b0);
        repeat (5) drive(1'b0, 2'd1, 4'hF, rnd64(), 1'b0, 1'b0);
        drive(1'b0, 2'd2, 4'hF, rnd64(), 1'b1, 1'b0);

        // Flush while full and ready.
        drive(1'b0, 2'd3, 4'hF, rnd64(), 1'b1, 1'b1);
        drive(1'b0, 2'd0, 4'h0, rnd64(), 1'b1, 1'b0);

        // Out-of-range select with a held word.
        drive(1'b0, 2'd1, 4'hF, rnd64(), 1'b0, 1'b0);
        drive(1'b0, 2'd3, 4'hF, rnd64(), 1'b0, 1'b0);
        drive(1'b0, 2'd0, 4'h0, rnd64(), 1'b0, 1'b0);
        drive(1'b0, 2'd0, 4'h0, rnd64(), 1'b1, 1'b0);

        // Async reset mid-stream with a word held.
        drive(1'b1, 2'd0, 4'hF, rnd64(), 1'b1, 1'b0);
        drive(1'b0, 2'd2, 4'hF, rnd64(), 1'b0, 1'b0);
        @(posedge clk);
        #6;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        reset_model();
        idle_inputs();
        repeat (2) @(posedge clk);
        #6;
        rst_n = 1'b1;
        repeat (3) drive(1'b1, 2'd0, 4'hF, rnd64(), 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), rnd64(),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
        end

        // Drain.
        repeat (3) drive(1'b0, 2'd0, 4'h0, 64'h0, 1'b1, 1'b0);
        @(posedge clk);
        #4;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
